// File: rtl/riscv_branch_resolve_ctrl.sv
// Branch resolution for the dual-issue EXE stage: mispredict detection, age-ordered
// redirect to fetch, younger-work flush, serialised predictor updates and counters.

module riscv_branch_slot_eval (
   input  logic        valid,
   input  logic        branch,
   input  logic        stall,
   input  logic        taken,
   input  logic        jump,
   input  logic        pred_taken,
   input  logic [31:0] pc,
   input  logic [31:0] target,
   input  logic [31:0] pred_target,
   output logic        res,
   output logic        mp,
   output logic        taken_eff,
   output logic [31:0] cpc
);
   // an unconditional jump is always taken, whatever the decoder reports
   assign taken_eff = taken | jump;
   assign res       = valid & branch & ~stall;
   assign mp        = res & ((taken_eff != pred_taken) | (taken_eff & (target != pred_target)));
   assign cpc       = taken_eff ? target : pc + 32'd4;
endmodule

module riscv_branch_resolve_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s0_valid,
   input  logic             s0_branch,
   input  logic             s0_taken,
   input  logic             s0_call,
   input  logic             s0_return,
   input  logic             s0_jump,
   input  logic [31:0]      s0_pc,
   input  logic [31:0]      s0_target,
   input  logic             s0_pred_taken,
   input  logic [31:0]      s0_pred_target,
   input  logic             s1_valid,
   input  logic             s1_branch,
   input  logic             s1_taken,
   input  logic             s1_call,
   input  logic             s1_return,
   input  logic             s1_jump,
   input  logic [31:0]      s1_pc,
   input  logic [31:0]      s1_target,
   input  logic             s1_pred_taken,
   input  logic [31:0]      s1_pred_target,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [31:0]      redirect_pc,
   output logic             flush_o,
   output logic             kill_s1_o,
   output logic             stall_o,
   output logic             bp_upd_valid,
   output logic [31:0]      bp_upd_pc,
   output logic             bp_upd_taken,
   output logic [31:0]      bp_upd_target,
   output logic             bp_upd_call,
   output logic             bp_upd_return,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);
   localparam int DW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = (FLUSH_CYCLES > 0) ? DW'(FLUSH_CYCLES - 1) : '0;
   localparam logic [DW-1:0] DRAIN_ONE  = 1;

   typedef enum logic [1:0] {IDLE, REDIR, DRAIN, UPD2} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
      logic        call;
      logic        ret;
   } upd_t;

   logic [1:0]       s_valid, s_branch, s_taken, s_jump, s_pred_taken, s_call, s_return;
   logic [1:0]       res, mp, taken_eff;
   logic [1:0][31:0] s_pc, s_target, s_pred_target, cpc;
   upd_t [1:0]       slot_upd;

   assign s_valid       = {s1_valid, s0_valid};
   assign s_branch      = {s1_branch, s0_branch};
   assign s_taken       = {s1_taken, s0_taken};
   assign s_jump        = {s1_jump, s0_jump};
   assign s_pred_taken  = {s1_pred_taken, s0_pred_taken};
   assign s_call        = {s1_call, s0_call};
   assign s_return      = {s1_return, s0_return};
   assign s_pc          = {s1_pc, s0_pc};
   assign s_target      = {s1_target, s0_target};
   assign s_pred_target = {s1_pred_target, s0_pred_target};

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_slot
         riscv_branch_slot_eval u_eval (
            .valid       (s_valid[g]),
            .branch      (s_branch[g]),
            .stall       (stall_o),
            .taken       (s_taken[g]),
            .jump        (s_jump[g]),
            .pred_taken  (s_pred_taken[g]),
            .pc          (s_pc[g]),
            .target      (s_target[g]),
            .pred_target (s_pred_target[g]),
            .res         (res[g]),
            .mp          (mp[g]),
            .taken_eff   (taken_eff[g]),
            .cpc         (cpc[g])
         );
         assign slot_upd[g] = {s_pc[g], taken_eff[g], s_target[g], s_call[g], s_return[g]};
      end
   endgenerate

   // slot0 is older: its mispredict squashes slot1 in the same cycle
   assign kill_s1_o = mp[0];

   state_t          state, state_d;
   logic            rv_d, flush_d;
   logic [31:0]     rpc_d;
   logic [DW-1:0]   drain_cnt, drain_d;
   logic            pend_v, pend_v_d, upd_v_d;
   upd_t            pend, pend_d, upd_d, bp_q;
   logic [1:0]      br_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      rv_d    = redirect_valid;
      rpc_d   = redirect_pc;
      flush_d = 1'b0;
      drain_d = drain_cnt;
      case (state)
         IDLE: begin
            if (mp[0] | mp[1]) begin
               state_d = REDIR;
               rv_d    = 1'b1;
               flush_d = 1'b1;
               rpc_d   = mp[0] ? cpc[0] : cpc[1];
            end else if (res[0] & res[1]) begin
               state_d = UPD2;
            end
         end
         REDIR: begin
            if (redirect_valid & redirect_ready) begin
               rv_d = 1'b0;
               if (FLUSH_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  drain_d = DRAIN_LOAD;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (drain_cnt == '0) state_d = IDLE;
            else                 drain_d = drain_cnt - DRAIN_ONE;
         end
         UPD2:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Predictor update port: new resolutions go first, the buffered younger update
   // follows one cycle later while the FSM is out of IDLE (so no new resolutions).
   always_comb begin
      upd_v_d  = 1'b0;
      upd_d    = pend;
      pend_v_d = 1'b0;
      pend_d   = pend;
      if (res[0]) begin
         upd_v_d = 1'b1;
         upd_d   = slot_upd[0];
         if (res[1] & ~mp[0]) begin
            pend_v_d = 1'b1;
            pend_d   = slot_upd[1];
         end
      end else if (res[1]) begin
         upd_v_d = 1'b1;
         upd_d   = slot_upd[1];
      end else if (pend_v) begin
         upd_v_d = 1'b1;
      end
   end

   assign br_inc = {1'b0, res[0]} + {1'b0, res[1] & ~mp[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush_o        <= 1'b0;
         stall_o        <= 1'b0;
         drain_cnt      <= '0;
         pend_v         <= 1'b0;
         pend           <= '0;
         bp_upd_valid   <= 1'b0;
         bp_q           <= '0;
         branch_cnt     <= '0;
         mispred_cnt    <= '0;
      end else begin
         redirect_valid <= rv_d;
         redirect_pc    <= rpc_d;
         flush_o        <= flush_d;
         stall_o        <= (state_d != IDLE);
         drain_cnt      <= drain_d;
         pend_v         <= pend_v_d;
         pend           <= pend_d;
         bp_upd_valid   <= upd_v_d;
         if (upd_v_d) bp_q <= upd_d;
         branch_cnt     <= branch_cnt + CNT_W'(br_inc);
         if (mp[0] | mp[1]) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
   end

   assign bp_upd_pc     = bp_q.pc;
   assign bp_upd_taken  = bp_q.taken;
   assign bp_upd_target = bp_q.target;
   assign bp_upd_call   = bp_q.call;
   assign bp_upd_return = bp_q.ret;
endmodule

// File: tb/tb_riscv_branch_resolve_ctrl.sv
// Directed and random checks of riscv_branch_resolve_ctrl against a rule-level
// scoreboard of expected redirects, stalls, predictor updates and counters.

module tb_riscv_branch_resolve_ctrl;
   localparam int FLUSH = 2;
   localparam int CW    = 4;

   typedef struct {
      logic        valid, branch, taken, call, ret, jump, pred_taken;
      logic [31:0] pc, target, pred_target;
   } slot_t;

   typedef struct {
      logic [31:0] pc, target;
      logic        taken, call, ret;
   } upd_t;

   logic clk = 1'b0;
   logic rst_n;
   logic s0_valid, s0_branch, s0_taken, s0_call, s0_return, s0_jump, s0_pred_taken;
   logic s1_valid, s1_branch, s1_taken, s1_call, s1_return, s1_jump, s1_pred_taken;
   logic [31:0] s0_pc, s0_target, s0_pred_target, s1_pc, s1_target, s1_pred_target;
   logic redirect_valid, redirect_ready, flush_o, kill_s1_o, stall_o;
   logic [31:0] redirect_pc, bp_upd_pc, bp_upd_target;
   logic bp_upd_valid, bp_upd_taken, bp_upd_call, bp_upd_return;
   logic [CW-1:0] branch_cnt, mispred_cnt;

   riscv_branch_resolve_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_valid(s0_valid), .s0_branch(s0_branch), .s0_taken(s0_taken), .s0_call(s0_call),
      .s0_return(s0_return), .s0_jump(s0_jump), .s0_pc(s0_pc), .s0_target(s0_target),
      .s0_pred_taken(s0_pred_taken), .s0_pred_target(s0_pred_target),
      .s1_valid(s1_valid), .s1_branch(s1_branch), .s1_taken(s1_taken), .s1_call(s1_call),
      .s1_return(s1_return), .s1_jump(s1_jump), .s1_pc(s1_pc), .s1_target(s1_target),
      .s1_pred_taken(s1_pred_taken), .s1_pred_target(s1_pred_target),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
      .flush_o(flush_o), .kill_s1_o(kill_s1_o), .stall_o(stall_o),
      .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc), .bp_upd_taken(bp_upd_taken),
      .bp_upd_target(bp_upd_target), .bp_upd_call(bp_upd_call), .bp_upd_return(bp_upd_return),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // scoreboard: expected registered outputs for the coming cycle
   logic          m_stall, m_rv, m_flush, m_uv, m_pv, exp_kill;
   logic [31:0]   m_rpc;
   upd_t          m_upd, m_pend;
   int            m_rem;
   logic [CW-1:0] m_bc, m_mc;
   slot_t         cur0, cur1;
   logic          cur_rdy;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic slot_t idle_slot();
      slot_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic slot_t br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                input logic ptk, input logic [31:0] ptgt);
      slot_t s;
      s = idle_slot();
      s.valid = 1'b1; s.branch = 1'b1; s.pc = pc; s.taken = tk; s.target = tgt;
      s.pred_taken = ptk; s.pred_target = ptgt;
      return s;
   endfunction

   function automatic upd_t to_upd(input slot_t s);
      upd_t u;
      u.pc = s.pc; u.target = s.target; u.taken = s.taken; u.call = s.call; u.ret = s.ret;
      return u;
   endfunction

   task automatic model_reset();
      m_stall = 0; m_rv = 0; m_flush = 0; m_uv = 0; m_pv = 0; m_rpc = 0; m_rem = 0;
      m_bc = 0; m_mc = 0; exp_kill = 0;
   endtask

   task automatic model_step();
      bit r0, r1, p0, p1;
      logic [31:0] c0, c1;
      r0 = cur0.valid && cur0.branch && !m_stall;
      r1 = cur1.valid && cur1.branch && !m_stall;
      p0 = r0 && ((cur0.taken != cur0.pred_taken) || (cur0.taken && cur0.target != cur0.pred_target));
      p1 = r1 && ((cur1.taken != cur1.pred_taken) || (cur1.taken && cur1.target != cur1.pred_target));
      c0 = cur0.taken ? cur0.target : cur0.pc + 32'd4;
      c1 = cur1.taken ? cur1.target : cur1.pc + 32'd4;
      exp_kill = p0;
      m_flush = 0;
      m_uv = 0;
      if (m_pv) begin m_uv = 1; m_upd = m_pend; m_pv = 0; end
      if (r0) begin
         m_uv = 1; m_upd = to_upd(cur0);
         if (r1 && !p0) begin m_pv = 1; m_pend = to_upd(cur1); end
      end else if (r1) begin
         m_uv = 1; m_upd = to_upd(cur1);
      end
      m_bc = m_bc + CW'(r0) + CW'(r1 && !p0);
      if (p0 || p1) m_mc = m_mc + CW'(1);
      if (m_rv && cur_rdy) begin m_rv = 0; m_rem = FLUSH; end
      if (p0 || p1) begin m_rv = 1; m_flush = 1; m_rpc = p0 ? c0 : c1; end
      m_stall = m_rv || m_pv || (m_rem > 0);
      if (m_rem > 0) m_rem--;
   endtask

   task automatic check_model();
      chk("stall", 32'(stall_o), 32'(m_stall));
      chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
      chk("flush", 32'(flush_o), 32'(m_flush));
      if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
      chk("bp_valid", 32'(bp_upd_valid), 32'(m_uv));
      if (m_uv) begin
         chk("bp_pc", bp_upd_pc, m_upd.pc);
         chk("bp_taken", 32'(bp_upd_taken), 32'(m_upd.taken));
         chk("bp_target", bp_upd_target, m_upd.target);
         chk("bp_call", 32'(bp_upd_call), 32'(m_upd.call));
         chk("bp_return", 32'(bp_upd_return), 32'(m_upd.ret));
      end
      chk("branch_cnt", 32'(branch_cnt), 32'(m_bc));
      chk("mispred_cnt", 32'(mispred_cnt), 32'(m_mc));
   endtask

   task automatic drive(input slot_t a, input slot_t b, input logic rdy);
      cur0 = a; cur1 = b; cur_rdy = rdy;
      s0_valid = a.valid; s0_branch = a.branch; s0_taken = a.taken; s0_call = a.call;
      s0_return = a.ret; s0_jump = a.jump; s0_pc = a.pc; s0_target = a.target;
      s0_pred_taken = a.pred_taken; s0_pred_target = a.pred_target;
      s1_valid = b.valid; s1_branch = b.branch; s1_taken = b.taken; s1_call = b.call;
      s1_return = b.ret; s1_jump = b.jump; s1_pc = b.pc; s1_target = b.target;
      s1_pred_taken = b.pred_taken; s1_pred_target = b.pred_target;
      redirect_ready = rdy;
   endtask

   // one clock: drive at negedge, check the combinational kill, then the registered outputs
   task automatic cycle(input slot_t a, input slot_t b, input logic rdy);
      drive(a, b, rdy);
      #1;
      model_step();
      chk("kill_s1", 32'(kill_s1_o), 32'(exp_kill));
      @(negedge clk);
      check_model();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rv"}, 32'(redirect_valid), 0);
      chk({tag, "_rpc"}, redirect_pc, 0);
      chk({tag, "_flush"}, 32'(flush_o), 0);
      chk({tag, "_stall"}, 32'(stall_o), 0);
      chk({tag, "_bpv"}, 32'(bp_upd_valid), 0);
      chk({tag, "_bppc"}, bp_upd_pc, 0);
      chk({tag, "_bcnt"}, 32'(branch_cnt), 0);
      chk({tag, "_mcnt"}, 32'(mispred_cnt), 0);
   endtask

   function automatic slot_t rnd_slot();
      slot_t s;
      s = idle_slot();
      s.valid  = ($urandom_range(99) < 75);
      s.branch = ($urandom_range(99) < 60);
      s.jump   = ($urandom_range(99) < 15);
      s.taken  = s.jump ? 1'b1 : 1'($urandom_range(1));
      s.call   = 1'($urandom_range(1));
      s.ret    = 1'($urandom_range(1));
      s.pc     = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      s.target = $urandom() & 32'hFFFF_FFFC;
      s.pred_taken  = ($urandom_range(99) < 70) ? s.taken : ~s.taken;
      s.pred_target = ($urandom_range(99) < 75) ? s.target : (s.target ^ 32'h4);
      return s;
   endfunction

   initial begin
      slot_t a, b, z;
      z = idle_slot();
      rst_n = 1'b0;
      drive(z, z, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("rst_init");
      rst_n = 1'b1;
      cycle(z, z, 1'b1);

      // slot0 taken mispredict kills slot1; redirect held until ready
      a = br(32'h100, 1, 32'h200, 0, 32'h0);
      b = br(32'h104, 0, 32'h0, 0, 32'h0);
      cycle(a, b, 1'b0);
      chk("A_rv", 32'(redirect_valid), 1);
      chk("A_rpc", redirect_pc, 32'h200);
      chk("A_flush", 32'(flush_o), 1);
      chk("A_stall", 32'(stall_o), 1);
      chk("A_bppc", bp_upd_pc, 32'h100);
      chk("A_bcnt", 32'(branch_cnt), 1);
      chk("A_mcnt", 32'(mispred_cnt), 1);
      cycle(br(32'h300, 1, 32'h500, 0, 32'h0), z, 1'b0);
      cycle(z, z, 1'b0);
      cycle(z, z, 1'b0);
      chk("A_hold_rpc", redirect_pc, 32'h200);
      chk("A_hold_flush", 32'(flush_o), 0);
      chk("A_hold_bcnt", 32'(branch_cnt), 1);
      cycle(z, z, 1'b1);
      chk("A_hs_rv", 32'(redirect_valid), 0);
      chk("A_drain1", 32'(stall_o), 1);
      cycle(z, z, 1'b0);
      chk("A_drain2", 32'(stall_o), 1);
      cycle(z, z, 1'b0);
      chk("A_idle", 32'(stall_o), 0);

      // slot1 not-taken mispredict behind a non-branch, then reset mid-redirect
      a = idle_slot(); a.valid = 1'b1; a.pc = 32'h3F8;
      b = br(32'h3FC, 0, 32'h1000, 1, 32'h1000);
      cycle(a, b, 1'b0);
      chk("B_rpc", redirect_pc, 32'h400);
      chk("B_bppc", bp_upd_pc, 32'h3FC);
      cycle(z, z, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(z, z, 1'b1);
      chk_all_zero("rst_after");

      // two correctly predicted branches serialise over the update port
      a = br(32'h10, 0, 32'h0, 0, 32'h0);
      b = br(32'h14, 1, 32'h40, 1, 32'h40);
      cycle(a, b, 1'b0);
      chk("C_bppc0", bp_upd_pc, 32'h10);
      chk("C_stall1", 32'(stall_o), 1);
      chk("C_bcnt", 32'(branch_cnt), 2);
      cycle(z, z, 1'b0);
      chk("C_bppc1", bp_upd_pc, 32'h14);
      chk("C_stall2", 32'(stall_o), 0);
      chk("C_mcnt", 32'(mispred_cnt), 0);

      // bring mispred_cnt to all-ones, then a target-only mispredict wraps it
      for (int i = 0; i < 20 && m_mc != {CW{1'b1}}; i++) begin
         cycle(br(32'h20, 1, 32'h60, 0, 32'h0), z, 1'b1);
         for (int k = 0; k < 4; k++) cycle(z, z, 1'b1);
      end
      chk("D_pre", 32'(mispred_cnt), 32'(CW'('1)));
      cycle(br(32'h70, 1, 32'h80, 1, 32'h84), z, 1'b0);
      chk("D_rpc", redirect_pc, 32'h80);
      chk("D_wrap", 32'(mispred_cnt), 0);
      for (int k = 0; k < 4; k++) cycle(z, z, 1'b1);

      // random traffic against the scoreboard
      for (int i = 0; i < 1500; i++) begin
         a = rnd_slot();
         b = rnd_slot();
         cycle(a, b, 1'($urandom_range(1)));
      end
      for (int k = 0; k < 6; k++) cycle(z, z, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/riscv_branch_resolve_ctrl.md
Name: riscv_branch_resolve_ctrl

Overview:
Sequences branch resolution for the dual-issue in-order EXE stage. It takes per-slot branch results from the EXE decoders (taken, target, call/return/jump) together with the fetch-time prediction, and detects mispredictions. It arbitrates by age: slot0 is older. It issues a single registered redirect with a valid/ready handshake to fetch, flushes younger work, and serialises branch-predictor updates over one update port. It also keeps branch and mispredict counters.

Parameters:
FLUSH_CYCLES, 2, cycles stall_o stays high after the redirect handshake (0 allowed)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
sN_valid  in  1  slot N (N=0,1) holds a valid EXE instruction this cycle
sN_branch  in  1  slot N instruction is a branch or jump
sN_taken  in  1  resolved direction
sN_call  in  1  resolved as a call
sN_return  in  1  resolved as a return
sN_jump  in  1  resolved as an unconditional jump
sN_pc  in  32  instruction PC
sN_target  in  32  resolved target
sN_pred_taken  in  1  fetch prediction, direction
sN_pred_target  in  32  fetch prediction, target
redirect_valid  out  1  redirect request to fetch
redirect_ready  in  1  fetch accepts the redirect
redirect_pc  out  32  correct next PC
flush_o  out  1  one-cycle pulse: kill all instructions younger than the mispredicting branch
kill_s1_o  out  1  combinational: slot1 killed this cycle (slot0 mispredicted)
stall_o  out  1  freeze issue/EXE; sN_valid is ignored while high
bp_upd_valid  out  1  predictor update strobe
bp_upd_pc  out  32  update PC
bp_upd_taken  out  1  update direction
bp_upd_target  out  32  update target
bp_upd_call  out  1  update call flag
bp_upd_return  out  1  update return flag
branch_cnt  out  CNT_W  count of resolved branches
mispred_cnt  out  CNT_W  count of mispredictions

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output register, counter, pending buffer and the drain counter go to 0; redirect_pc=0. This applies mid-redirect or mid-drain as well. No redirect is issued after reset.
- Resolution term: resN = sN_valid & sN_branch & ~stall_o.
- Misprediction term: mpN = resN & ((sN_taken != sN_pred_taken) | (sN_taken & (sN_target != sN_pred_target))).
- Correct PC: cpcN = sN_taken ? sN_target : sN_pc + 4, with 32-bit wrap.
- Age priority:
  - If mp0, slot1 is killed: kill_s1_o=1, no slot1 update, no slot1 count.
  - Otherwise slot1 is handled normally.
- Latency: all outputs except kill_s1_o are registered. Inputs sampled in cycle N affect outputs in cycle N+1.
- FSM:
  - IDLE:
    - On mp0 or (mp1 & ~mp0): redirect_pc <= cpc of the winning slot; redirect_valid <= 1; flush_o <= 1 for that single cycle; go to REDIR.
    - Else, if res0 & res1: go to UPD2 (second update pending).
    - Else: stay in IDLE.
  - REDIR:
    - redirect_valid and redirect_pc are held stable until redirect_ready.
    - flush_o=0 after the first cycle.
    - On handshake: redirect_valid <= 0. If FLUSH_CYCLES=0, go to IDLE; else load the drain counter with FLUSH_CYCLES-1 and go to DRAIN.
  - DRAIN: decrement each cycle; at 0, go to IDLE.
  - UPD2: emit the buffered slot1 update; go to IDLE next cycle.
- stall_o:
  - Registered; equals (next_state != IDLE).
  - High throughout REDIR, DRAIN and UPD2.
  - Low in the cycle following the return to IDLE.
- BP update:
  - One update per cycle. Every resolved, non-killed branch produces exactly one update with its resolved (not predicted) fields, mispredicting ones included.
  - Same cycle, both resolved, slot0 not mispredicted: slot0 update at N+1, slot1 at N+2 (via UPD2 or REDIR).
  - If slot1 mispredicts in that case: the redirect still starts at N+1 and the slot1 update goes out at N+2.
- Counters:
  - branch_cnt increments by the number of counted branches (0..2) per cycle.
  - mispred_cnt increments by 1 per accepted misprediction.
  - Both wrap at 2^CNT_W.
- redirect_ready while redirect_valid=0 is ignored.

Test Plan:
- Reset: drive rst_n=0 while in REDIR with redirect_valid=1 -> all outputs 0 immediately (async); after release, state IDLE and counters 0.
- Slot0 mispredict: s0 pc=0x100, taken=1, target=0x200, pred_taken=0; s1 also a valid branch -> kill_s1_o=1 in the same cycle. Next cycle: redirect_valid=1, redirect_pc=0x200, flush_o=1, stall_o=1; one update for pc 0x100; branch_cnt=1, mispred_cnt=1.
- Handshake hold and drain: keep redirect_ready=0 for 3 cycles -> redirect_pc stays 0x200 and flush_o is high for only 1 cycle. Then ready=1 -> redirect_valid drops, stall_o stays high for 2 more cycles (FLUSH_CYCLES=2), then goes low.
- Not-taken mispredict in slot1: s1 pc=0x3FC, taken=0, pred_taken=1 -> redirect_pc=0x400; slot0 non-branch is unaffected.
- Dual correct branches: s0 pc=0x10 and s1 pc=0x14, both correctly predicted -> bp_upd for 0x10 at N+1 and 0x14 at N+2; stall_o=1 at N+1 only; branch_cnt +2, mispred_cnt unchanged.
- Target mismatch and counter wrap: taken=1, pred_taken=1, target 0x80 vs pred 0x84 -> mispredict with redirect_pc=0x80. Preload mispred_cnt=0xFFFFFFFF -> wraps to 0.
